// File: rtl/cv32e40x_pkg.sv
// Shared types for the cv32e40x divider slice: opcode and FSM state encodings.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_opcode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        INIT   = 2'b01,
        DIVIDE = 2'b10,
        FINISH = 2'b11
    } div_state_e;

endpackage

// File: rtl/cv32e40x_alu_div_if.sv
// Request/response handshake between an issuing stage (master) and the divider (slave).
interface cv32e40x_alu_div_if;
    import cv32e40x_pkg::*;

    logic        valid_i;
    logic        ready_o;
    logic        kill_i;
    div_opcode_e op_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    modport master (
        output valid_i, kill_i, op_i, op_a_i, op_b_i, ready_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  valid_i, kill_i, op_i, op_a_i, op_b_i, ready_i,
        output ready_o, valid_o, result_o
    );

endinterface

// File: rtl/cv32e40x_alu_div.sv
// Iterative 32-bit restoring divider; normalisation uses the ALU's CLZ and left shifter
// through the div_* ports so that only the subtract/compare path lives here.
module cv32e40x_alu_div
    import cv32e40x_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    cv32e40x_alu_div_if.slave        div_if,
    output logic                     div_clz_en_o,
    output logic [31:0]              div_clz_data_o,
    input  logic [5:0]               div_clz_result_i,
    output logic                     div_shift_en_o,
    output logic [5:0]               div_shift_amt_o,
    output logic [31:0]              div_op_a_o,
    input  logic [31:0]              div_op_a_shifted_i
);

    div_state_e  state_q, state_d;
    div_opcode_e op_q;
    logic        sign_q;
    logic        sign_r;
    logic        div_by_zero_q;
    logic [4:0]  cnt_q;
    logic [31:0] quotient_q;
    logic [31:0] remainder_q;
    logic [31:0] divisor_q;
    logic [31:0] op_b_abs_q;

    logic        accept;
    logic        signed_op;
    logic        signed_op_q;
    logic        rem_ge_div;
    logic signed [31:0] op_a_s;
    logic signed [31:0] op_b_s;

    function automatic logic [31:0] negate(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // |0x80000000| stays 0x80000000, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs_val(input logic signed [31:0] v);
        return v[31] ? negate($unsigned(v)) : $unsigned(v);
    endfunction

    assign op_a_s      = div_if.op_a_i;
    assign op_b_s      = div_if.op_b_i;
    assign signed_op   = (div_if.op_i == DIV) || (div_if.op_i == REM);
    assign signed_op_q = (op_q == DIV) || (op_q == REM);
    assign accept      = div_if.valid_i & div_if.ready_o & ~div_if.kill_i;
    assign rem_ge_div  = (remainder_q >= divisor_q);

    always_comb begin
        state_d         = state_q;
        div_if.ready_o  = 1'b0;
        div_if.valid_o  = 1'b0;
        div_if.result_o = 32'd0;
        div_clz_en_o    = 1'b0;
        div_clz_data_o  = 32'd0;
        div_shift_en_o  = 1'b0;
        div_shift_amt_o = 6'd0;
        div_op_a_o      = 32'd0;

        case (state_q)
            IDLE: begin
                div_if.ready_o = 1'b1;
                if (div_if.valid_i) state_d = INIT;
            end
            INIT: begin
                div_clz_en_o    = 1'b1;
                div_clz_data_o  = op_b_abs_q;
                div_shift_en_o  = 1'b1;
                div_shift_amt_o = div_clz_result_i;
                div_op_a_o      = op_b_abs_q;
                // A count of 32 (bit 5 set) only occurs for a zero divisor.
                state_d = div_clz_result_i[5] ? FINISH : DIVIDE;
            end
            DIVIDE: begin
                if (cnt_q == 5'd0) state_d = FINISH;
            end
            FINISH: begin
                div_if.valid_o = 1'b1;
                case (op_q)
                    DIV:     div_if.result_o = (sign_q & ~div_by_zero_q) ? negate(quotient_q) : quotient_q;
                    DIVU:    div_if.result_o = quotient_q;
                    REM:     div_if.result_o = (sign_r & ~div_by_zero_q) ? negate(remainder_q) : remainder_q;
                    default: div_if.result_o = remainder_q;
                endcase
                if (div_if.ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (div_if.kill_i) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            op_q          <= DIV;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            div_by_zero_q <= 1'b0;
            cnt_q         <= 5'd0;
            quotient_q    <= 32'd0;
            remainder_q   <= 32'd0;
            divisor_q     <= 32'd0;
            op_b_abs_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                // accept: capture operand magnitudes and result signs
                IDLE: begin
                    if (accept) begin
                        op_q          <= div_if.op_i;
                        op_b_abs_q    <= signed_op ? abs_val(op_b_s) : div_if.op_b_i;
                        remainder_q   <= signed_op ? abs_val(op_a_s) : div_if.op_a_i;
                        sign_q        <= div_if.op_a_i[31] ^ div_if.op_b_i[31];
                        sign_r        <= div_if.op_a_i[31];
                        div_by_zero_q <= 1'b0;
                    end
                end
                // normalise: divisor MSB-aligned by the ALU shifter
                INIT: begin
                    divisor_q  <= div_op_a_shifted_i;
                    quotient_q <= 32'd0;
                    cnt_q      <= div_clz_result_i[4:0];
                    if (div_clz_result_i[5]) begin
                        quotient_q    <= 32'hFFFF_FFFF;
                        // Restore the original dividend from its stored magnitude.
                        remainder_q   <= (signed_op_q & sign_r) ? negate(remainder_q) : remainder_q;
                        div_by_zero_q <= 1'b1;
                    end
                end
                // iterate: one restoring subtract per cycle
                DIVIDE: begin
                    if (rem_ge_div) begin
                        remainder_q <= remainder_q - divisor_q;
                        quotient_q  <= {quotient_q[30:0], 1'b1};
                    end else begin
                        quotient_q  <= {quotient_q[30:0], 1'b0};
                    end
                    divisor_q <= {1'b0, divisor_q[31:1]};
                    cnt_q     <= cnt_q - 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40x_alu_div.sv
// Directed bench for cv32e40x_alu_div; a behavioural CLZ/shifter stands in for the ALU.
module tb_cv32e40x_alu_div;
    import cv32e40x_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_clz_en_o;
    logic [31:0] div_clz_data_o;
    logic [5:0]  div_clz_result_i;
    logic        div_shift_en_o;
    logic [5:0]  div_shift_amt_o;
    logic [31:0] div_op_a_o;
    logic [31:0] div_op_a_shifted_i;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    cv32e40x_alu_div_if div_if ();

    cv32e40x_alu_div dut (
        .clk                (clk),
        .rst                (rst),
        .div_if             (div_if.slave),
        .div_clz_en_o       (div_clz_en_o),
        .div_clz_data_o     (div_clz_data_o),
        .div_clz_result_i   (div_clz_result_i),
        .div_shift_en_o     (div_shift_en_o),
        .div_shift_amt_o    (div_shift_amt_o),
        .div_op_a_o         (div_op_a_o),
        .div_op_a_shifted_i (div_op_a_shifted_i)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] clz32(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) return 6'(31 - i);
        end
        return 6'd32;
    endfunction

    always_comb begin
        div_clz_result_i   = clz32(div_clz_data_o);
        div_op_a_shifted_i = div_op_a_o << div_shift_amt_o[4:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input div_opcode_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_absb,
                          input logic [31:0] exp_res, input int exp_lat, input int hold);
        int lat;
        div_if.valid_i = 1'b1;
        div_if.op_i    = op;
        div_if.op_a_i  = a;
        div_if.op_b_i  = b;
        @(posedge clk); #1;
        div_if.valid_i = 1'b0;
        lat = 1;
        check({tag, "_busy"},   32'(div_if.ready_o), 32'd0);
        check({tag, "_clz_en"}, 32'(div_clz_en_o),   32'd1);
        check({tag, "_clz_in"}, div_clz_data_o,      exp_absb);
        while (div_if.valid_o !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, div_if.result_o, exp_res);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_vld"}, 32'(div_if.valid_o), 32'd1);
            check({tag, "_hold_res"}, div_if.result_o, exp_res);
        end
        div_if.ready_i = 1'b1;
        @(posedge clk); #1;
        div_if.ready_i = 1'b0;
        check({tag, "_done_vld"}, 32'(div_if.valid_o), 32'd0);
        check({tag, "_done_rdy"}, 32'(div_if.ready_o), 32'd1);
    endtask

    initial begin
        int seen;
        rst            = 1'b1;
        div_if.valid_i = 1'b0;
        div_if.kill_i  = 1'b0;
        div_if.ready_i = 1'b0;
        div_if.op_i    = DIVU;
        div_if.op_a_i  = 32'd0;
        div_if.op_b_i  = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_ready",    32'(div_if.ready_o), 32'd1);
        check("rst_valid",    32'(div_if.valid_o), 32'd0);
        check("rst_result",   div_if.result_o,     32'd0);
        check("rst_clz_en",   32'(div_clz_en_o),   32'd0);
        check("rst_shift_en", 32'(div_shift_en_o), 32'd0);

        run_op("divu_100_7",  DIVU, 32'd100,        32'd7,          32'd7,          32'd14,         32, 0);
        run_op("remu_100_7",  REMU, 32'd100,        32'd7,          32'd7,          32'd2,          32, 0);
        run_op("div_m100_7",  DIV,  32'hFFFF_FF9C,  32'd7,          32'd7,          32'hFFFF_FFF2,  32, 0);
        run_op("rem_m100_7",  REM,  32'hFFFF_FF9C,  32'd7,          32'd7,          32'hFFFF_FFFE,  32, 0);
        run_op("divu_5_0",    DIVU, 32'd5,          32'd0,          32'd0,          32'hFFFF_FFFF,  2,  0);
        run_op("rem_m5_0",    REM,  32'hFFFF_FFFB,  32'd0,          32'd0,          32'hFFFF_FFFB,  2,  0);
        run_op("div_m5_0",    DIV,  32'hFFFF_FFFB,  32'd0,          32'd0,          32'hFFFF_FFFF,  2,  0);
        run_op("div_ovf",     DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'd1,          32'h8000_0000,  34, 0);
        run_op("rem_ovf",     REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd1,          32'd0,          34, 0);
        run_op("divu_msb",    DIVU, 32'hC000_0000,  32'h8000_0000,  32'h8000_0000,  32'd1,          3,  0);
        run_op("rem_7_m3",    REM,  32'd7,          32'hFFFF_FFFD,  32'd3,          32'd1,          33, 5);

        // kill beats a simultaneous accept in IDLE
        div_if.valid_i = 1'b1;
        div_if.kill_i  = 1'b1;
        div_if.op_i    = DIVU;
        div_if.op_a_i  = 32'd100;
        div_if.op_b_i  = 32'd7;
        @(posedge clk); #1;
        div_if.valid_i = 1'b0;
        div_if.kill_i  = 1'b0;
        check("kill_vs_accept", 32'(div_if.ready_o), 32'd1);

        // kill in DIVIDE
        div_if.valid_i = 1'b1;
        @(posedge clk); #1;
        div_if.valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 div_if.kill_i = 1'b1;
        @(posedge clk); #1;
        div_if.kill_i = 1'b0;
        check("kill_ready", 32'(div_if.ready_o), 32'd1);
        check("kill_valid", 32'(div_if.valid_o), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (div_if.valid_o === 1'b1) seen++;
        end
        check("kill_no_valid", 32'(seen), 32'd0);

        // rst in DIVIDE
        div_if.valid_i = 1'b1;
        @(posedge clk); #1;
        div_if.valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_ready", 32'(div_if.ready_o), 32'd1);
        check("rst_mid_valid", 32'(div_if.valid_o), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (div_if.valid_o === 1'b1) seen++;
        end
        check("rst_mid_no_valid", 32'(seen), 32'd0);

        run_op("after_rst", DIVU, 32'd100, 32'd7, 32'd7, 32'd14, 32, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cv32e40x_alu_div.md
CV32E40X_ALU_DIV -- requirements
Module: cv32e40x_alu_div

Interface
REQ-001 Parameters: none; the block SHALL be fully fixed at 32-bit width.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 valid_i  in  1  request valid.
REQ-005 ready_o  out  1  divider can accept a request.
REQ-006 kill_i  in  1  abort the current operation.
REQ-007 op_i  in  2  div_opcode_e operation: DIV, DIVU, REM, REMU.
REQ-008 op_a_i  in  32  dividend.
REQ-009 op_b_i  in  32  divisor.
REQ-010 valid_o  out  1  result valid.
REQ-011 ready_i  in  1  consumer accepts the result.
REQ-012 result_o  out  32  quotient or remainder.
REQ-013 div_clz_en_o  out  1  request the ALU CLZ unit.
REQ-014 div_clz_data_o  out  32  CLZ operand.
REQ-015 div_clz_result_i  in  6  ALU CLZ count, 0..32, where 32 means the operand is zero.
REQ-016 div_shift_en_o  out  1  request an ALU left shift.
REQ-017 div_shift_amt_o  out  6  shift amount; the ALU uses bits [4:0].
REQ-018 div_op_a_o  out  32  value to be muxed into ALU operand A while div_shift_en_o=1.
REQ-019 div_op_a_shifted_i  in  32  ALU shifter result.

Function
REQ-020 FSM states (div_state_e): IDLE, INIT, DIVIDE, FINISH.
REQ-021 ready_o SHALL be 1 only in IDLE.
REQ-022 Accept on valid_i&ready_o: latch op_i, |a|, |b| (absolute value only for DIV/REM), sign_q=a[31]^b[31], sign_r=a[31]; next state INIT.
REQ-023 In INIT, outputs SHALL be:
- div_clz_en_o=1, div_clz_data_o=|b|.
- div_shift_en_o=1, div_shift_amt_o=div_clz_result_i, div_op_a_o=|b|.
- All three outputs SHALL be 0 in every other state.
REQ-024 INIT register loads:
- divisor_q = div_op_a_shifted_i.
- remainder_q = |a|, quotient_q = 0.
- cnt_q = div_clz_result_i[4:0].
REQ-025 INIT with |b|==0 (div_clz_result_i=32):
- quotient SHALL be 0xFFFFFFFF and remainder SHALL be a, with no sign correction.
- Next state SHALL be FINISH.
REQ-026 INIT with |b|!=0: next state DIVIDE.
REQ-027 DIVIDE, each cycle:
- If remainder_q >= divisor_q (unsigned): remainder_q -= divisor_q and shift 1 into quotient_q LSB; otherwise shift 0.
- divisor_q >>= 1.
- cnt_q decrements; after the iteration with cnt_q==0 the next state SHALL be FINISH.
- Total iterations SHALL be clz+1.
REQ-028 FINISH:
- valid_o=1.
- result_o SHALL be quotient (DIV/DIVU) or remainder (REM/REMU).
- For DIV the quotient SHALL be negated when sign_q; for REM the remainder SHALL be negated when sign_r; this does not apply to divide-by-zero.
- Hold until ready_i=1, then go to IDLE.
- result_o SHALL be 0 when valid_o=0.
REQ-029 Latency from the accept cycle to valid_o rise SHALL be clz(|b|)+3 cycles (range 3..34), or 2 cycles for divide-by-zero.
REQ-030 Signed overflow (0x80000000 / -1) SHALL give quotient 0x80000000 and remainder 0 via the normal path.
REQ-031 kill_i=1 in any state SHALL force IDLE next cycle with no valid_o.
REQ-032 kill_i has priority over accept and over ready_i.
REQ-033 valid_i is ignored while ready_o=0.
REQ-034 valid_o SHALL NOT drop without ready_i, kill_i or rst; result_o SHALL be stable while valid_o=1.

Reset
REQ-035 Reset values: state IDLE, cnt_q/quotient_q/remainder_q/divisor_q=0, valid_o=0, result_o=0, div_clz_en_o=0, div_shift_en_o=0.
REQ-036 ready_o SHALL be 1 in the first cycle after rst deasserts.
REQ-037 rst asserted mid-operation SHALL discard the operation; no valid_o SHALL follow.

Structure
REQ-038 div_opcode_e (2-bit) and div_state_e SHALL be defined in cv32e40x_pkg.
REQ-039 No sub-module: CLZ and the shifter are borrowed from cv32e40x_alu through the div_* ports; the subtractor/comparator is local.

Verification
REQ-040 DIVU a=100, b=7 -> result 14, valid_o 3+29=32 cycles after accept; REMU same operands -> 2.
REQ-041 DIV a=0xFFFFFF9C (-100), b=7 -> 0xFFFFFFF2 (-14); REM -> 0xFFFFFFFE (-2).
REQ-042 DIVU a=5, b=0 -> 0xFFFFFFFF after 2 cycles; REM a=0xFFFFFFFB, b=0 -> 0xFFFFFFFB.
REQ-043 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 in 34 cycles; REM -> 0.
REQ-044 Boundary and handshake:
- DIVU b=0x80000000 -> valid_o after exactly 3 cycles.
- Hold ready_i=0 for 5 cycles -> valid_o and result_o stable.
- Assert kill_i, then rst, in DIVIDE -> no valid_o, ready_o=1 next cycle.
